// File: rtl/display_pkg.sv
// Shared constants for the chess-clock display: seven-segment font,
// player codes and the digit-slot numbering used by the scan index.
package display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] PLAYER_1 = 2'b01;
  localparam logic [1:0] PLAYER_2 = 2'b10;

  // Slot number equals the anode bit that the slot drives low
  localparam logic [2:0] SLOT_M1_TENS  = 3'd7;
  localparam logic [2:0] SLOT_M1_UNITS = 3'd6;
  localparam logic [2:0] SLOT_S1_TENS  = 3'd5;
  localparam logic [2:0] SLOT_S1_UNITS = 3'd4;
  localparam logic [2:0] SLOT_M2_TENS  = 3'd3;
  localparam logic [2:0] SLOT_M2_UNITS = 3'd2;
  localparam logic [2:0] SLOT_S2_TENS  = 3'd1;
  localparam logic [2:0] SLOT_S2_UNITS = 3'd0;

  function automatic logic [6:0] seg_font(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    case (digit)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin_to_bcd60.sv
// Combinational split of a 0..59 binary value into decimal tens/units;
// valid_o drops for values above 59.
module bin_to_bcd60 (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = (bin_i <= 6'd59);
    if      (bin_i >= 6'd50) tens_o = 4'd5;
    else if (bin_i >= 6'd40) tens_o = 4'd4;
    else if (bin_i >= 6'd30) tens_o = 4'd3;
    else if (bin_i >= 6'd20) tens_o = 4'd2;
    else if (bin_i >= 6'd10) tens_o = 4'd1;
    else                     tens_o = 4'd0;
    // Remainder is below 10, so nibble-wide modular subtraction is exact
    units_o = bin_i[3:0] - tens_o * 4'd10;
  end

endmodule

// File: rtl/display_scan.sv
// Eight-digit MM.SS | MM.SS scanner for the chess clock: frame-coherent
// snapshot, active-player marker and blinking of an expired player's time.
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] min1,
  input  logic [5:0] sec1,
  input  logic [5:0] min2,
  input  logic [5:0] sec2,
  input  logic [1:0] player,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic          pcnt_wrap, bcnt_wrap, frame_wrap;

  // Snapshot fields: [3]=min1 [2]=sec1 [1]=min2 [0]=sec2, so idx[2:1] selects the field
  logic [5:0]    snap_q [4];
  logic [1:0]    player_q;

  logic [3:0]    tens_w  [4];
  logic [3:0]    units_w [4];
  logic          valid_w [4];

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [1:0]    fld;
  logic [3:0]    digit;
  logic          exp1, exp2, blank_slot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcd
      bin_to_bcd60 u_bcd (
        .bin_i   (snap_q[gi]),
        .tens_o  (tens_w[gi]),
        .units_o (units_w[gi]),
        .valid_o (valid_w[gi])
      );
    end
  endgenerate

  always_comb begin
    pcnt_wrap  = (pcnt_q == PCNT_LAST);
    bcnt_wrap  = (bcnt_q == BCNT_LAST);
    frame_wrap = pcnt_wrap && (idx_q == SLOT_S2_UNITS);
    pcnt_d     = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    bcnt_d     = bcnt_wrap ? '0 : bcnt_q + 1'b1;
    idx_d      = pcnt_wrap ? idx_q - 3'd1 : idx_q;
    phase_d    = bcnt_wrap ? ~phase_q : phase_q;
  end

  always_comb begin
    fld   = idx_q[2:1];
    digit = idx_q[0] ? tens_w[fld] : units_w[fld];
    seg_d = valid_w[fld] ? seg_font(digit) : SEG_DASH;

    dp_d = 1'b1;
    if (idx_q == SLOT_M1_UNITS || idx_q == SLOT_M2_UNITS)
      dp_d = 1'b0;
    if (idx_q == SLOT_S1_UNITS && player_q == PLAYER_1)
      dp_d = 1'b0;
    if (idx_q == SLOT_S2_UNITS && player_q == PLAYER_2)
      dp_d = 1'b0;

    exp1       = (snap_q[3] == 6'd0) && (snap_q[2] == 6'd0);
    exp2       = (snap_q[1] == 6'd0) && (snap_q[0] == 6'd0);
    blank_slot = !phase_q && (idx_q[2] ? exp1 : exp2);
    an_d       = blank_slot ? 8'hFF : ~(8'd1 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q   <= '0;
      bcnt_q   <= '0;
      idx_q    <= 3'd7;
      phase_q  <= 1'b1;
      an_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      pcnt_q   <= pcnt_d;
      bcnt_q   <= bcnt_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
    // New values only enter at frame boundaries so a frame never mixes two times
    if (reset || frame_wrap) begin
      snap_q[3] <= min1;
      snap_q[2] <= sec1;
      snap_q[1] <= min2;
      snap_q[0] <= sec2;
      player_q  <= player;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed table-driven bench for display_scan with a 4-cycle slot and
// 64-cycle blink half-period.
module tb_display_scan;

  localparam logic [6:0] F0   = 7'b1000000;
  localparam logic [6:0] F1   = 7'b1111001;
  localparam logic [6:0] F2   = 7'b0100100;
  localparam logic [6:0] F3   = 7'b0110000;
  localparam logic [6:0] F4   = 7'b0011001;
  localparam logic [6:0] F5   = 7'b0010010;
  localparam logic [6:0] F9   = 7'b0010000;
  localparam logic [6:0] FD   = 7'b0111111;
  localparam logic [6:0] FX   = 7'b1111111;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         chk;
  } slot_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] min1, sec1, min2, sec2;
  logic [1:0] player;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;
  slot_t tbl [7][8];

  display_scan #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .min1   (min1),
    .sec1   (sec1),
    .min2   (min2),
    .sec2   (sec2),
    .player (player),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int f, input int s,
                     input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s table=%0d slot=%0d got=%h want=%h", name, f, s, got, want);
    end
  endtask

  task automatic check_reset_outputs(input int tag);
    chk("reset_an",  tag, 0, an, 8'hFF);
    chk("reset_seg", tag, 0, {1'b0, seg}, 8'h7F);
    chk("reset_dp",  tag, 0, {7'b0, dp}, 8'h01);
  endtask

  // Each slot must hold its pattern for exactly four cycles
  task automatic check_slots(input int f, input int s_from, input int s_to);
    for (int s = s_from; s <= s_to; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk("an", f, s, an, tbl[f][s].an);
        if (tbl[f][s].chk) begin
          chk("seg", f, s, {1'b0, seg}, {1'b0, tbl[f][s].seg});
          chk("dp",  f, s, {7'b0, dp}, {7'b0, tbl[f][s].dp});
        end
      end
      $display("[TB] table %0d slot %0d an=%h seg=%b dp=%b", f, s, an, seg, dp);
    end
  endtask

  initial begin
    // 0: 12:34 | 05:09, player 1
    tbl[0][0] = '{8'h7F, F1, 1'b1, 1'b1};
    tbl[0][1] = '{8'hBF, F2, 1'b0, 1'b1};
    tbl[0][2] = '{8'hDF, F3, 1'b1, 1'b1};
    tbl[0][3] = '{8'hEF, F4, 1'b0, 1'b1};
    tbl[0][4] = '{8'hF7, F0, 1'b1, 1'b1};
    tbl[0][5] = '{8'hFB, F5, 1'b0, 1'b1};
    tbl[0][6] = '{8'hFD, F0, 1'b1, 1'b1};
    tbl[0][7] = '{8'hFE, F9, 1'b1, 1'b1};
    // 1: 12:33 | 05:09, player 1
    tbl[1] = tbl[0];
    tbl[1][3].seg = F3;
    // 2: 12:33 | 00:00 in blink-off phase
    tbl[2] = tbl[1];
    for (int s = 4; s < 8; s++) tbl[2][s] = '{8'hFF, FX, 1'b1, 1'b0};
    // 3: 12:33 | 00:00 in blink-on phase
    tbl[3] = tbl[1];
    tbl[3][5].seg = F0;
    tbl[3][7].seg = F0;
    // 4: 63:33 (dashes) | 00:00 blink-off
    tbl[4] = tbl[2];
    tbl[4][0].seg = FD;
    tbl[4][1].seg = FD;
    // 5: 12:33 | 05:09, no player running
    tbl[5] = tbl[1];
    tbl[5][3].dp = 1'b1;
    // 6: 12:33 | 05:09, player 2
    tbl[6] = tbl[5];
    tbl[6][7].dp = 1'b0;

    reset = 1'b1;
    min1 = 6'd12; sec1 = 6'd34; min2 = 6'd5; sec2 = 6'd9; player = 2'b01;
    step();
    step();
    check_reset_outputs(0);
    reset = 1'b0;

    check_slots(0, 0, 7);                 // frame 1
    check_slots(0, 0, 0);                 // frame 2: change mid-frame
    sec1 = 6'd33;
    check_slots(0, 1, 7);
    check_slots(1, 0, 0);                 // frame 3 shows 33
    min2 = 6'd0; sec2 = 6'd0;
    check_slots(1, 1, 7);
    check_slots(2, 0, 7);                 // frame 4: blink off
    check_slots(3, 0, 7);                 // frame 5: blink on
    check_slots(3, 0, 7);                 // frame 6: blink on
    check_slots(2, 0, 0);                 // frame 7: blink off
    min1 = 6'd63;
    check_slots(2, 1, 7);
    check_slots(4, 0, 0);                 // frame 8: dashes
    min1 = 6'd12; min2 = 6'd5; sec2 = 6'd9; player = 2'b11;
    check_slots(4, 1, 7);
    check_slots(5, 0, 7);                 // frame 9: no player
    check_slots(5, 0, 3);                 // frame 10: reset during slot 3

    step();
    chk("slot3_an", 5, 4, an, 8'hF7);
    player = 2'b10;
    reset = 1'b1;
    step();
    check_reset_outputs(1);
    reset = 1'b0;
    check_slots(6, 0, 7);                 // restarts at slot 7, snapshot reloaded

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
